// File: rtl/float_norm_arbiter.sv
// Round-robin arbiter feeding a shared leading-zero counter and normalizing shifter.
// Two-stage pipeline (S1 capture, S2 normalized result) sustains one result per cycle.

module float_naive_lzc #(
  parameter int WIDTH       = 24,
  parameter int OUTPUT_STEP = 1,
  parameter int OUTPUT_BIAS = 0,
  parameter int OUT_WIDTH   = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [OUT_WIDTH-1:0] count_o
);

  int cnt;

  // The highest set bit is visited last, so it determines the count.
  always_comb begin
    cnt = WIDTH;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_i[i]) cnt = WIDTH - 1 - i;
    end
    count_o = OUT_WIDTH'(cnt * OUTPUT_STEP + OUTPUT_BIAS);
  end

endmodule

module float_norm_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MANT_WIDTH = 24,
  parameter int EXP_WIDTH  = 8,
  parameter int LZC_WIDTH  = $clog2(MANT_WIDTH + 1),
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*MANT_WIDTH-1:0]   req_mant,
  input  logic [NUM_REQ*EXP_WIDTH-1:0]    req_exp,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ID_WIDTH-1:0]             out_id,
  output logic [MANT_WIDTH-1:0]           out_mant,
  output logic [EXP_WIDTH-1:0]            out_exp,
  output logic                            out_zero,
  output logic                            out_underflow
);

  localparam int CMP_WIDTH = (LZC_WIDTH > EXP_WIDTH) ? LZC_WIDTH : EXP_WIDTH;

  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_WIDTH'(s);
  endfunction

  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [ID_WIDTH-1:0]   s1_id_q, s1_id_d;
  logic [MANT_WIDTH-1:0] s1_mant_q, s1_mant_d;
  logic [EXP_WIDTH-1:0]  s1_exp_q, s1_exp_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [ID_WIDTH-1:0]   s2_id_q, s2_id_d;
  logic [MANT_WIDTH-1:0] s2_mant_q, s2_mant_d;
  logic [EXP_WIDTH-1:0]  s2_exp_q, s2_exp_d;
  logic                  s2_zero_q, s2_zero_d;
  logic                  s2_uf_q, s2_uf_d;

  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  s1_free, s2_free, accept, s1_move;
  logic [LZC_WIDTH-1:0]  lzc_n;
  logic [MANT_WIDTH-1:0] norm_mant;
  logic [EXP_WIDTH-1:0]  norm_exp;
  logic                  norm_zero, norm_uf;

  // Descending offsets so the requester closest to ptr overrides later finds.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  assign s2_free = !s2_valid_q | out_ready;
  assign s1_free = !s1_valid_q | s2_free;
  assign accept  = grant_found & s1_free & !rst;
  assign s1_move = s1_valid_q & s2_free;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  float_naive_lzc #(
    .WIDTH      (MANT_WIDTH),
    .OUTPUT_STEP(1),
    .OUTPUT_BIAS(0),
    .OUT_WIDTH  (LZC_WIDTH)
  ) u_lzc (
    .in_i   (s1_mant_q),
    .count_o(lzc_n)
  );

  // When the exponent cannot absorb the full shift, stop at exponent 0 and flag it.
  always_comb begin
    norm_mant = '0;
    norm_exp  = '0;
    norm_zero = 1'b0;
    norm_uf   = 1'b0;
    if (s1_mant_q == '0) begin
      norm_zero = 1'b1;
    end else if (CMP_WIDTH'(lzc_n) <= CMP_WIDTH'(s1_exp_q)) begin
      norm_mant = s1_mant_q << lzc_n;
      norm_exp  = s1_exp_q - EXP_WIDTH'(lzc_n);
    end else begin
      norm_mant = s1_mant_q << s1_exp_q;
      norm_uf   = 1'b1;
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_mant_d  = s1_mant_q;
    s1_exp_d   = s1_exp_q;
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_mant_d  = s2_mant_q;
    s2_exp_d   = s2_exp_q;
    s2_zero_d  = s2_zero_q;
    s2_uf_d    = s2_uf_q;
    if (accept) begin
      ptr_d      = wrap_add(grant_idx, 1);
      s1_valid_d = 1'b1;
      s1_id_d    = grant_idx;
      s1_mant_d  = req_mant[int'(grant_idx)*MANT_WIDTH +: MANT_WIDTH];
      s1_exp_d   = req_exp[int'(grant_idx)*EXP_WIDTH +: EXP_WIDTH];
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end
    if (s1_move) begin
      s2_valid_d = 1'b1;
      s2_id_d    = s1_id_q;
      s2_mant_d  = norm_mant;
      s2_exp_d   = norm_exp;
      s2_zero_d  = norm_zero;
      s2_uf_d    = norm_uf;
    end else if (s2_valid_q && out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_mant_q  <= '0;
      s2_exp_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_uf_q    <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_mant_q  <= s1_mant_d;
      s1_exp_q   <= s1_exp_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_mant_q  <= s2_mant_d;
      s2_exp_q   <= s2_exp_d;
      s2_zero_q  <= s2_zero_d;
      s2_uf_q    <= s2_uf_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_id        = s2_id_q;
  assign out_mant      = s2_mant_q;
  assign out_exp       = s2_exp_q;
  assign out_zero      = s2_zero_q;
  assign out_underflow = s2_uf_q;

endmodule

// File: tb/tb_float_norm_arbiter.sv
// Directed bench for float_norm_arbiter: arbitration order, normalization corner
// cases, backpressure buffering and mid-flight reset, each with hand-computed results.

module tb_float_norm_arbiter;

  localparam int N  = 4;
  localparam int MW = 24;
  localparam int EW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*MW-1:0] req_mant;
  logic [N*EW-1:0] req_exp;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_id;
  logic [MW-1:0]   out_mant;
  logic [EW-1:0]   out_exp;
  logic            out_zero;
  logic            out_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  float_norm_arbiter #(.NUM_REQ(N), .MANT_WIDTH(MW), .EXP_WIDTH(EW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mant     (req_mant),
    .req_exp      (req_exp),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_id       (out_id),
    .out_mant     (out_mant),
    .out_exp      (out_exp),
    .out_zero     (out_zero),
    .out_underflow(out_underflow)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int i, input logic [MW-1:0] m, input logic [EW-1:0] e);
    req_mant[i*MW +: MW] = m;
    req_exp[i*EW +: EW]  = e;
  endtask

  task automatic pulseReset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    req_valid = '1;
    out_ready = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_id: got %0d want 0", out_id); end
    checks++; if (out_mant !== 24'h0) begin errors++; $display("[TB] FAIL reset_mant: got %h want 0", out_mant); end
    checks++; if (out_exp !== 8'd0) begin errors++; $display("[TB] FAIL reset_exp: got %0d want 0", out_exp); end
    checks++; if (out_zero !== 1'b0 || out_underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got zero=%b uf=%b want 0 0", out_zero, out_underflow); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0000", req_ready); end
    rst       = 1'b0;
    req_valid = '0;
    tick();
  endtask

  task automatic test_single;
    out_ready = 1'b1;
    setReq(0, 24'h000100, 8'd20);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid: got %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("[TB] FAIL single_id: got %0d want 0", out_id); end
    checks++; if (out_mant !== 24'h800000) begin errors++; $display("[TB] FAIL single_mant: got %h want 800000", out_mant); end
    checks++; if (out_exp !== 8'd5) begin errors++; $display("[TB] FAIL single_exp: got %0d want 5", out_exp); end
    checks++; if (out_zero !== 1'b0 || out_underflow !== 1'b0) begin errors++; $display("[TB] FAIL single_flags: got zero=%b uf=%b want 0 0", out_zero, out_underflow); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_special;
    logic [MW-1:0] inM[5]  = '{24'h000000, 24'h800000, 24'h000001, 24'h000001, 24'h000001};
    logic [EW-1:0] inE[5]  = '{8'd77, 8'd9, 8'd3, 8'd23, 8'd22};
    logic [MW-1:0] expM[5] = '{24'h000000, 24'h800000, 24'h000008, 24'h800000, 24'h400000};
    logic [EW-1:0] expE[5] = '{8'd0, 8'd9, 8'd0, 8'd0, 8'd0};
    logic          expZ[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic          expU[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      setReq(2, inM[v], inE[v]);
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      tick();
      checks++; if (out_valid !== 1'b1 || out_id !== 2'd2) begin errors++; $display("[TB] FAIL special%0d_valid_id: got valid=%b id=%0d want 1 2", v, out_valid, out_id); end
      checks++; if (out_mant !== expM[v]) begin errors++; $display("[TB] FAIL special%0d_mant: got %h want %h", v, out_mant, expM[v]); end
      checks++; if (out_exp !== expE[v]) begin errors++; $display("[TB] FAIL special%0d_exp: got %0d want %0d", v, out_exp, expE[v]); end
      checks++; if (out_zero !== expZ[v] || out_underflow !== expU[v]) begin errors++; $display("[TB] FAIL special%0d_flags: got zero=%b uf=%b want %b %b", v, out_zero, out_underflow, expZ[v], expU[v]); end
      tick();
    end
  endtask

  task automatic test_round_robin;
    pulseReset();
    for (int i = 0; i < N; i++) setReq(i, 24'h800000 >> i, 8'd10);
    req_valid = 4'hF;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << (c % 4))) begin errors++; $display("[TB] FAIL rr_ready%0d: got %b want %b", c, req_ready, 4'(1 << (c % 4))); end
      if (c >= 2) begin
        checks++; if (out_valid !== 1'b1 || out_id !== 2'((c - 2) % 4)) begin errors++; $display("[TB] FAIL rr_out%0d: got valid=%b id=%0d want 1 %0d", c, out_valid, out_id, (c - 2) % 4); end
        checks++; if (out_exp !== 8'(10 - ((c - 2) % 4)) || out_mant !== 24'h800000) begin errors++; $display("[TB] FAIL rr_data%0d: got exp=%0d mant=%h want %0d 800000", c, out_exp, out_mant, 10 - ((c - 2) % 4)); end
      end
      tick();
    end
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_backpressure;
    int accepts;
    accepts = 0;
    pulseReset();
    for (int i = 0; i < N; i++) setReq(i, 24'h800000 >> i, 8'd10);
    req_valid = 4'hF;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (|(req_ready & req_valid)) accepts++;
      if (c >= 2) begin
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_ready%0d: got %b want 0000", c, req_ready); end
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_exp !== 8'd10) begin errors++; $display("[TB] FAIL bp_hold%0d: got valid=%b id=%0d exp=%0d want 1 0 10", c, out_valid, out_id, out_exp); end
      end
      tick();
    end
    checks++; if (accepts !== 2) begin errors++; $display("[TB] FAIL bp_accepts: got %0d want 2", accepts); end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_id !== 2'(c % 4) || out_exp !== 8'(10 - (c % 4))) begin errors++; $display("[TB] FAIL bp_resume%0d: got valid=%b id=%0d exp=%0d want 1 %0d %0d", c, out_valid, out_id, out_exp, c % 4, 10 - (c % 4)); end
      tick();
    end
    req_valid = '0;
    tick();
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midflight;
    pulseReset();
    for (int i = 0; i < N; i++) setReq(i, 24'h800000 >> i, 8'd10);
    req_valid = 4'hF;
    out_ready = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_full: got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL mid_ready_in_rst: got %b want 0000", req_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_id !== 2'd0) begin errors++; $display("[TB] FAIL mid_valid_id: got valid=%b id=%0d want 0 0", out_valid, out_id); end
    checks++; if (out_mant !== 24'h0 || out_exp !== 8'd0) begin errors++; $display("[TB] FAIL mid_data: got mant=%h exp=%0d want 0 0", out_mant, out_exp); end
    checks++; if (out_zero !== 1'b0 || out_underflow !== 1'b0) begin errors++; $display("[TB] FAIL mid_flags: got zero=%b uf=%b want 0 0", out_zero, out_underflow); end
    rst       = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_partial: got %b want 0", out_valid); end
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL mid_first_grant: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_exp !== 8'd9) begin errors++; $display("[TB] FAIL mid_result: got valid=%b id=%0d exp=%0d want 1 1 9", out_valid, out_id, out_exp); end
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_mant  = '0;
    req_exp   = '0;
    out_ready = 1'b0;
    $display("[TB] starting float_norm_arbiter bench");
    test_reset();
    test_single();
    test_special();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
